// File: rtl/pb_pkg.sv
// Shared types and constants for the protobuf wire-format tokenizer.
// Holds the wire-type, token-kind and error-code encodings and the
// default varint length limit.
package pb_pkg;

  localparam int MAX_VARINT_BYTES = 10;
  localparam int MAX_KEY_BYTES    = 5;

  typedef enum logic [2:0] {
    WT_VARINT = 3'd0,
    WT_I64    = 3'd1,
    WT_LEN    = 3'd2,
    WT_SGROUP = 3'd3,
    WT_EGROUP = 3'd4,
    WT_I32    = 3'd5
  } wire_type_e;

  typedef enum logic [1:0] {
    TK_SCALAR   = 2'd0,
    TK_LEN_HDR  = 2'd1,
    TK_LEN_BYTE = 2'd2
  } tok_kind_e;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_BAD_WIRE   = 3'd1,
    ERR_BAD_KEY    = 3'd2,
    ERR_VARINT_OVF = 3'd3,
    ERR_LEN_OVF    = 3'd4,
    ERR_TRUNC      = 3'd5
  } err_code_e;

endpackage

// File: rtl/pb_varint_accum.sv
// Little-endian base-128 varint accumulator.
//   clk, rst_n : clock, async active-low reset
//   en         : a varint byte is being consumed this cycle
//   clear      : restart at byte 0 (wins over en)
//   data       : stream byte
//   limit      : maximum number of bytes allowed in this varint
//   acc        : value including the current byte (combinational)
//   done       : current byte terminates the varint
//   ovf        : current byte is byte number `limit` and still continues
module pb_varint_accum (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clear,
  input  logic [7:0]  data,
  input  logic [3:0]  limit,
  output logic [63:0] acc,
  output logic        done,
  output logic        ovf
);
  import pb_pkg::*;

  logic [63:0] acc_q;
  logic [3:0]  cnt_q;
  logic [6:0]  shamt;

  // At byte 10 the shift is 63, so only data bit 0 survives in the
  // 64-bit result and bits 6:1 fall off the top.
  always_comb begin
    shamt = {3'b000, cnt_q} * 7'd7;
    acc   = acc_q | ({57'd0, data[6:0]} << shamt);
    done  = en && !data[7];
    ovf   = en && data[7] && (cnt_q == limit - 4'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 64'd0;
      cnt_q <= 4'd0;
    end else if (clear) begin
      acc_q <= 64'd0;
      cnt_q <= 4'd0;
    end else if (en) begin
      acc_q <= acc;
      cnt_q <= cnt_q + 4'd1;
    end
  end

endmodule

// File: rtl/pb_stream_tokenizer.sv
// Streaming protobuf wire-format tokenizer: splits a byte stream into
// key+scalar tokens, or a length header followed by payload byte tokens.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : byte handshake; in_data byte, in_last ends message
//   tok_valid/tok_ready : token handshake (single output register)
//   tok_kind/field/wire : token kind, field number, wire type
//   tok_value           : scalar value, length, or payload byte in [7:0]
//   tok_last            : token's final byte carried in_last
//   err_valid/err_code  : one-cycle error pulse, code held until next error
//
// state     | meaning
// ----------+-------------------------------------------------
// S_KEY     | collecting key varint (max 5 bytes)
// S_VARINT  | collecting value varint
// S_FIX64   | collecting 8 little-endian bytes
// S_FIX32   | collecting 4 little-endian bytes
// S_LEN     | collecting length varint
// S_PAYLOAD | forwarding length-delimited payload bytes
// S_DRAIN   | discarding bytes after an error until in_last
module pb_stream_tokenizer #(
  parameter int MAX_VARINT_BYTES = pb_pkg::MAX_VARINT_BYTES,
  parameter int LEN_W            = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        tok_valid,
  input  logic        tok_ready,
  output logic [1:0]  tok_kind,
  output logic [28:0] tok_field,
  output logic [2:0]  tok_wire,
  output logic [63:0] tok_value,
  output logic        tok_last,
  output logic        err_valid,
  output logic [2:0]  err_code
);
  import pb_pkg::*;

  localparam logic [2:0] S_KEY     = 3'd0;
  localparam logic [2:0] S_VARINT  = 3'd1;
  localparam logic [2:0] S_FIX64   = 3'd2;
  localparam logic [2:0] S_FIX32   = 3'd3;
  localparam logic [2:0] S_LEN     = 3'd4;
  localparam logic [2:0] S_PAYLOAD = 3'd5;
  localparam logic [2:0] S_DRAIN   = 3'd6;

  logic [2:0]       state, state_nxt;
  logic [LEN_W-1:0] cnt_rem, cnt_nxt;
  logic [63:0]      fix_val;
  logic [28:0]      key_field;
  logic [2:0]       key_wire;

  logic             accept;
  logic             acc_en, acc_clr, acc_done, acc_ovf;
  logic [3:0]       acc_limit;
  logic [63:0]      acc;
  logic [28:0]      key_field_c;
  logic [2:0]       key_wire_c;
  logic             wire_ok;

  logic             emit, err, ld_key;
  tok_kind_e        emit_kind;
  logic [63:0]      emit_val;
  err_code_e        err_cd;

  assign in_ready = rst_n && ((state == S_DRAIN) || !tok_valid || tok_ready);
  assign accept   = in_valid && in_ready;

  assign acc_en    = accept && (state == S_KEY || state == S_VARINT || state == S_LEN);
  // Any byte that ends the varint (normally, by overflow, or by in_last)
  // resets the accumulator so the next varint starts from byte 0.
  assign acc_clr   = acc_en && (acc_done || acc_ovf || in_last);
  assign acc_limit = (state == S_KEY) ? 4'(MAX_KEY_BYTES) : 4'(MAX_VARINT_BYTES);

  pb_varint_accum u_accum (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (acc_en),
    .clear (acc_clr),
    .data  (in_data),
    .limit (acc_limit),
    .acc   (acc),
    .done  (acc_done),
    .ovf   (acc_ovf)
  );

  assign key_field_c = acc[31:3];
  assign key_wire_c  = acc[2:0];
  assign wire_ok     = key_wire_c inside {WT_VARINT, WT_I64, WT_LEN, WT_I32};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_rem;
    emit      = 1'b0;
    emit_kind = TK_SCALAR;
    emit_val  = 64'd0;
    err       = 1'b0;
    err_cd    = ERR_NONE;
    ld_key    = 1'b0;
    if (accept) begin
      case (state)
        S_KEY: begin
          if (acc_ovf) begin
            err = 1'b1; err_cd = ERR_VARINT_OVF;
          end else if (acc_done) begin
            if (!wire_ok) begin
              err = 1'b1; err_cd = ERR_BAD_WIRE;
            end else if (key_field_c == 29'd0) begin
              err = 1'b1; err_cd = ERR_BAD_KEY;
            end else if (in_last) begin
              err = 1'b1; err_cd = ERR_TRUNC;
            end else begin
              ld_key = 1'b1;
              case (wire_type_e'(key_wire_c))
                WT_I64:  begin state_nxt = S_FIX64; cnt_nxt = LEN_W'(8); end
                WT_I32:  begin state_nxt = S_FIX32; cnt_nxt = LEN_W'(4); end
                WT_LEN:  state_nxt = S_LEN;
                default: state_nxt = S_VARINT;
              endcase
            end
          end else if (in_last) begin
            err = 1'b1; err_cd = ERR_TRUNC;
          end
        end
        S_VARINT: begin
          if (acc_ovf) begin
            err = 1'b1; err_cd = ERR_VARINT_OVF;
          end else if (acc_done) begin
            emit = 1'b1; emit_val = acc; state_nxt = S_KEY;
          end else if (in_last) begin
            err = 1'b1; err_cd = ERR_TRUNC;
          end
        end
        S_FIX64, S_FIX32: begin
          if (cnt_rem == LEN_W'(1)) begin
            emit      = 1'b1;
            emit_val  = (state == S_FIX64) ? {in_data, fix_val[63:8]}
                                           : {32'd0, in_data, fix_val[63:40]};
            state_nxt = S_KEY;
          end else if (in_last) begin
            err = 1'b1; err_cd = ERR_TRUNC;
          end else begin
            cnt_nxt = cnt_rem - LEN_W'(1);
          end
        end
        S_LEN: begin
          if (acc_ovf) begin
            err = 1'b1; err_cd = ERR_VARINT_OVF;
          end else if (acc_done) begin
            if ((acc >> LEN_W) != 64'd0) begin
              err = 1'b1; err_cd = ERR_LEN_OVF;
            end else if (acc == 64'd0) begin
              emit = 1'b1; emit_kind = TK_LEN_HDR; state_nxt = S_KEY;
            end else if (in_last) begin
              err = 1'b1; err_cd = ERR_TRUNC;
            end else begin
              emit      = 1'b1;
              emit_kind = TK_LEN_HDR;
              emit_val  = acc;
              cnt_nxt   = acc[LEN_W-1:0];
              state_nxt = S_PAYLOAD;
            end
          end else if (in_last) begin
            err = 1'b1; err_cd = ERR_TRUNC;
          end
        end
        S_PAYLOAD: begin
          if (cnt_rem == LEN_W'(1)) begin
            emit = 1'b1; emit_kind = TK_LEN_BYTE;
            emit_val = {56'd0, in_data}; state_nxt = S_KEY;
          end else if (in_last) begin
            err = 1'b1; err_cd = ERR_TRUNC;
          end else begin
            emit = 1'b1; emit_kind = TK_LEN_BYTE;
            emit_val = {56'd0, in_data}; cnt_nxt = cnt_rem - LEN_W'(1);
          end
        end
        S_DRAIN: begin
          if (in_last) state_nxt = S_KEY;
        end
        default: state_nxt = S_KEY;
      endcase
      // A bad field on the message's last byte has nothing left to drain.
      if (err) state_nxt = in_last ? S_KEY : S_DRAIN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_KEY;
      cnt_rem   <= '0;
      fix_val   <= 64'd0;
      key_field <= 29'd0;
      key_wire  <= 3'd0;
    end else begin
      state   <= state_nxt;
      cnt_rem <= cnt_nxt;
      if (accept && (state == S_FIX64 || state == S_FIX32))
        fix_val <= {in_data, fix_val[63:8]};
      if (ld_key) begin
        key_field <= key_field_c;
        key_wire  <= key_wire_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok_valid <= 1'b0;
      tok_kind  <= 2'd0;
      tok_field <= 29'd0;
      tok_wire  <= 3'd0;
      tok_value <= 64'd0;
      tok_last  <= 1'b0;
      err_valid <= 1'b0;
      err_code  <= 3'd0;
    end else begin
      if (emit) begin
        tok_valid <= 1'b1;
        tok_kind  <= emit_kind;
        tok_field <= key_field;
        tok_wire  <= key_wire;
        tok_value <= emit_val;
        tok_last  <= in_last;
      end else if (tok_ready) begin
        tok_valid <= 1'b0;
      end
      err_valid <= err;
      if (err) err_code <= err_cd;
    end
  end

endmodule
